// File: rtl/mmio_pkg.sv
// Shared constants and types for the mmio_bank I/O front end.
package mmio_pkg;
   localparam int IO_W = 16;

   localparam logic [15:0] IN_BASE_DFLT   = 16'hffe0;
   localparam logic [15:0] OUT_BASE_DFLT  = 16'hf010;
   localparam logic [15:0] STAT_ADDR_DFLT = 16'hfffe;

   // Status word layout: input-full flags low, output-pending flags high.
   localparam int STAT_IN_LSB  = 0;
   localparam int STAT_OUT_LSB = 8;
   localparam int STAT_FIELD_W = 8;

   // Bit of an output-channel read that carries the sticky overrun flag.
   localparam int OVR_BIT = 15;

   typedef enum logic {SEL_MEM = 1'b0, SEL_IO = 1'b1} io_sel_e;
endpackage

// File: rtl/memory.sv
// Dual-port byte memory with one-cycle synchronous read on both ports.
module memory #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic                  we_a,
   input  logic                  we_b,
   output logic [DATA_WIDTH-1:0] q_a,
   output logic [DATA_WIDTH-1:0] q_b
);
   logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

   // Read-during-write returns the old contents.
   always_ff @(posedge clk) begin
      if (we_a) mem_q[addr_a] <= data_a;
      if (we_b) mem_q[addr_b] <= data_b;
      q_a <= mem_q[addr_a];
      q_b <= mem_q[addr_b];
   end
endmodule

// File: rtl/mmio_in_chan.sv
// One input channel: single-word hold register with valid/ready capture
// and clear-on-read of the full flag.
module mmio_in_chan #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   input  logic         rd_i,
   output logic         in_ready_o,
   output logic         full_o,
   output logic [W-1:0] hold_o
);
   logic [W-1:0] hold_q, hold_d;
   logic         full_q, full_d;

   // A read while empty leaves the stale word in place and the flag clear.
   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      if (in_valid_i && !full_q) begin
         hold_d = in_data_i;
         full_d = 1'b1;
      end else if (rd_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
      end
   end

   assign in_ready_o = ~full_q;
   assign full_o     = full_q;
   assign hold_o     = hold_q;
endmodule

// File: rtl/mmio_bank.sv
// Memory-mapped I/O front end: wraps the dual-port memory and overlays
// input channels, latched output channels and a status word on port A.
module mmio_bank
   import mmio_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    N_IN       = 2,
   parameter int                    N_OUT      = 2,
   parameter logic [ADDR_WIDTH-1:0] IN_BASE    = ADDR_WIDTH'(IN_BASE_DFLT),
   parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = ADDR_WIDTH'(OUT_BASE_DFLT),
   parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = ADDR_WIDTH'(STAT_ADDR_DFLT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   data_a,
   input  logic [DATA_WIDTH-1:0]   data_b,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic                    we_a,
   input  logic                    we_b,
   output logic [2*DATA_WIDTH-1:0] q,
   input  logic [16*N_IN-1:0]      in_data,
   input  logic [N_IN-1:0]         in_valid,
   output logic [N_IN-1:0]         in_ready,
   output logic [16*N_OUT-1:0]     out_data,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ack
);
   logic [N_IN-1:0]             hit_in, rd_in, in_full;
   logic [N_IN-1:0][IO_W-1:0]   in_hold;
   logic [N_OUT-1:0]            hit_out;
   logic                        hit_stat, io_hit;
   logic [DATA_WIDTH-1:0]       q_a, q_b;
   logic [N_OUT-1:0][IO_W-1:0]  out_data_q, out_data_d;
   logic [N_OUT-1:0]            out_valid_q, out_valid_d;
   logic [N_OUT-1:0]            overrun_q, overrun_d;
   logic [IO_W-1:0]             io_rdata_q, io_rdata_d;
   io_sel_e                     io_sel_q, io_sel_d;
   logic [IO_W-1:0]             wr_word;

   assign wr_word = IO_W'({data_a, data_b});

   // Port A address is the only source of I/O decode.
   always_comb begin
      hit_in  = '0;
      hit_out = '0;
      for (int i = 0; i < N_IN; i++)
         hit_in[i] = (addr_a == IN_BASE + ADDR_WIDTH'(2 * i));
      for (int i = 0; i < N_OUT; i++)
         hit_out[i] = (addr_a == OUT_BASE + ADDR_WIDTH'(2 * i));
      hit_stat = (addr_a == STAT_ADDR);
      io_hit   = (|hit_in) | (|hit_out) | hit_stat;
   end

   assign rd_in = hit_in & {N_IN{~we_a}};

   memory #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_memory (
      .clk    (clk),
      .data_a (data_a),
      .data_b (data_b),
      .addr_a (addr_a),
      .addr_b (addr_b),
      .we_a   (we_a & ~io_hit),
      .we_b   (we_b & ~io_hit),
      .q_a    (q_a),
      .q_b    (q_b)
   );

   for (genvar g = 0; g < N_IN; g++) begin : g_in
      mmio_in_chan #(.W(IO_W)) u_chan (
         .clk_i      (clk),
         .rst_ni     (reset),
         .in_data_i  (in_data[IO_W*g +: IO_W]),
         .in_valid_i (in_valid[g]),
         .rd_i       (rd_in[g]),
         .in_ready_o (in_ready[g]),
         .full_o     (in_full[g]),
         .hold_o     (in_hold[g])
      );
   end

   // Write beats ack on the same edge; overrun only when the old word was never taken.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      if (hit_stat && !we_a) overrun_d = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (we_a && hit_out[i]) begin
            out_data_d[i]  = wr_word;
            out_valid_d[i] = 1'b1;
            if (out_valid_q[i] && !out_ack[i]) overrun_d[i] = 1'b1;
         end else if (out_ack[i]) begin
            out_valid_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      io_rdata_d = '0;
      for (int i = 0; i < N_IN; i++)
         if (hit_in[i]) io_rdata_d = in_hold[i];
      for (int i = 0; i < N_OUT; i++)
         if (hit_out[i]) begin
            io_rdata_d          = out_data_q[i];
            io_rdata_d[OVR_BIT] = overrun_q[i];
         end
      if (hit_stat) begin
         io_rdata_d[STAT_IN_LSB  +: STAT_FIELD_W] = STAT_FIELD_W'(in_full);
         io_rdata_d[STAT_OUT_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(out_valid_q);
      end
      io_sel_d = io_hit ? SEL_IO : SEL_MEM;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data_q  <= '0;
         out_valid_q <= '0;
         overrun_q   <= '0;
         io_rdata_q  <= '0;
         io_sel_q    <= SEL_MEM;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         io_rdata_q  <= io_rdata_d;
         io_sel_q    <= io_sel_d;
      end
   end

   assign q         = (io_sel_q == SEL_IO) ? (2*DATA_WIDTH)'(io_rdata_q) : {q_a, q_b};
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mmio_bank.sv
// Scoreboard bench for mmio_bank: expected read words are queued when a read
// is issued and popped when q presents the result one edge later.
module tb_mmio_bank;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_a, data_b;
   logic [15:0] addr_a, addr_b;
   logic        we_a, we_b;
   logic [15:0] q;
   logic [31:0] in_data;
   logic [1:0]  in_valid, in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_valid, out_ack;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_w, got_w;

   mmio_bank dut (
      .clk(clk), .reset(reset), .data_a(data_a), .data_b(data_b),
      .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b), .q(q),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_a = 1'b0; we_b = 1'b0;
      addr_a = 16'h0000; addr_b = 16'h0001;
      data_a = 8'h00; data_b = 8'h00;
      in_valid = 2'b00; out_ack = 2'b00;
   endtask

   task automatic wr_io(input logic [15:0] a, input logic [15:0] d);
      addr_a = a; {data_a, data_b} = d; we_a = 1'b1; we_b = 1'b0;
      cyc();
      idle();
   endtask

   task automatic rd_issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
      addr_a = a; addr_b = b; we_a = 1'b0; we_b = 1'b0;
      sb.push_back(exp);
      cyc();
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_data = '0;
      idle();
      for (int k = 0; k < 6; k++) begin
         data_a = 8'($urandom); data_b = 8'($urandom);
         addr_a = 16'($urandom); addr_b = 16'($urandom_range(16'h0400, 16'h04ff));
         we_a = 1'($urandom); we_b = 1'($urandom);
         in_data = $urandom; in_valid = 2'($urandom); out_ack = 2'($urandom);
         cyc();
      end
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL rst_out_valid got=%h exp=00", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 2'b11) $display("FAIL rst_in_ready got=%h exp=11", in_ready); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'h0) $display("FAIL rst_out_data got=%h exp=0", out_data); else pass_cnt++;
      idle();
      reset = 1'b1;
      cyc();
      chk_cnt++; if (in_ready !== 2'b11) $display("FAIL rel_in_ready got=%h exp=11", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL rel_out_valid got=%h exp=00", out_valid); else pass_cnt++;
   endtask

   task automatic test_memory();
      addr_a = 16'h0100; data_a = 8'h12; we_a = 1'b1;
      addr_b = 16'h0101; data_b = 8'h34; we_b = 1'b1;
      cyc();
      idle();
      rd_issue(16'h0100, 16'h0101, 16'h1234);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL mem_rd got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      // seed memory[f010] through port B, then hit it with a gated I/O write
      addr_a = 16'h0200; addr_b = 16'hf010; data_b = 8'h5a; we_b = 1'b1;
      cyc();
      idle();
      addr_a = 16'hf010; addr_b = 16'hf010; data_a = 8'haa; data_b = 8'hbb; we_a = 1'b1; we_b = 1'b1;
      cyc();
      idle();
      rd_issue(16'h0100, 16'hf010, 16'h125a);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL mem_io_gate got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      chk_cnt++; if (out_data[15:0] !== 16'haabb) $display("FAIL mem_out0_data got=%h exp=aabb", out_data[15:0]); else pass_cnt++;
      out_ack = 2'b01;
      cyc();
      idle();
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL mem_ack got=%h exp=00", out_valid); else pass_cnt++;
   endtask

   task automatic test_input();
      in_data = 32'h0000_beef; in_valid = 2'b01;
      cyc();
      in_valid = 2'b00;
      chk_cnt++; if (in_ready !== 2'b10) $display("FAIL in_full got=%h exp=10", in_ready); else pass_cnt++;
      rd_issue(16'hffe0, 16'h0001, 16'hbeef);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL in_read got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      chk_cnt++; if (in_ready !== 2'b11) $display("FAIL in_clear got=%h exp=11", in_ready); else pass_cnt++;
      rd_issue(16'hffe0, 16'h0001, 16'hbeef);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL in_stale got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      chk_cnt++; if (in_ready !== 2'b11) $display("FAIL in_empty_rd got=%h exp=11", in_ready); else pass_cnt++;
   endtask

   task automatic test_output();
      wr_io(16'hf012, 16'hcafe);
      chk_cnt++; if (out_data[31:16] !== 16'hcafe) $display("FAIL out_data1 got=%h exp=cafe", out_data[31:16]); else pass_cnt++;
      cyc(); cyc();
      chk_cnt++; if (out_valid !== 2'b10) $display("FAIL out_hold got=%h exp=10", out_valid); else pass_cnt++;
      addr_a = 16'hf012; {data_a, data_b} = 16'h1357; we_a = 1'b1; out_ack = 2'b10;
      cyc();
      idle();
      chk_cnt++; if (out_data[31:16] !== 16'h1357) $display("FAIL out_wr_ack_data got=%h exp=1357", out_data[31:16]); else pass_cnt++;
      chk_cnt++; if (out_valid !== 2'b10) $display("FAIL out_wr_ack_valid got=%h exp=10", out_valid); else pass_cnt++;
      out_ack = 2'b10;
      cyc();
      idle();
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL out_ack got=%h exp=00", out_valid); else pass_cnt++;
      rd_issue(16'hf012, 16'h0001, 16'h1357);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL out_read_no_ovr got=%h exp=%h", got_w, exp_w); else pass_cnt++;
   endtask

   task automatic test_overrun();
      wr_io(16'hf010, 16'h1111);
      wr_io(16'hf010, 16'h2222);
      rd_issue(16'hf010, 16'h0001, 16'ha222);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL ovr_set got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      rd_issue(16'hfffe, 16'h0001, 16'h0100);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL ovr_stat got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      rd_issue(16'hf010, 16'h0001, 16'h2222);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL ovr_clear got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      out_ack = 2'b01;
      cyc();
      idle();
   endtask

   task automatic test_status();
      in_data = 32'h4321_0000; in_valid = 2'b10;
      cyc();
      in_valid = 2'b00;
      wr_io(16'hf010, 16'h0042);
      rd_issue(16'hfffe, 16'h0001, 16'h0102);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL stat_word got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      rd_issue(16'hffe2, 16'h0001, 16'h4321);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL stat_in1 got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      rd_issue(16'hfffe, 16'h0001, 16'h0100);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL stat_after got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      out_ack = 2'b01;
      cyc();
      idle();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         addr_a = 16'h0300 + 16'(2 * k); data_a = 8'(8'h20 + k);
         addr_b = 16'h0301 + 16'(2 * k); data_b = 8'(8'hc0 + k);
         we_a = 1'b1; we_b = 1'b1;
         cyc();
      end
      idle();
      // mem and I/O reads interleaved on consecutive edges
      for (int k = 0; k < 4; k++) begin
         addr_a = 16'h0300 + 16'(2 * k); addr_b = 16'h0301 + 16'(2 * k);
         sb.push_back({8'(8'h20 + k), 8'(8'hc0 + k)});
         cyc();
         got_w = q; exp_w = sb.pop_front();
         chk_cnt++; if (got_w !== exp_w) $display("FAIL b2b_mem%0d got=%h exp=%h", k, got_w, exp_w); else pass_cnt++;
         addr_a = 16'hf010; addr_b = 16'h0001;
         sb.push_back(16'h0042);
         cyc();
         got_w = q; exp_w = sb.pop_front();
         chk_cnt++; if (got_w !== exp_w) $display("FAIL b2b_io%0d got=%h exp=%h", k, got_w, exp_w); else pass_cnt++;
      end
      idle();
   endtask

   task automatic test_reset_mid();
      in_data = 32'h0000_7777; in_valid = 2'b01;
      cyc();
      in_valid = 2'b00;
      wr_io(16'hf012, 16'h0bad);
      #2 reset = 1'b0;
      #1;
      chk_cnt++; if (in_ready !== 2'b11) $display("FAIL mid_in_ready got=%h exp=11", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL mid_out_valid got=%h exp=00", out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'h0) $display("FAIL mid_out_data got=%h exp=0", out_data); else pass_cnt++;
      cyc();
      reset = 1'b1;
      rd_issue(16'hffe0, 16'h0001, 16'h0000);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL mid_hold got=%h exp=%h", got_w, exp_w); else pass_cnt++;
      rd_issue(16'hf012, 16'h0001, 16'h0000);
      got_w = q; exp_w = sb.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL mid_out_rd got=%h exp=%h", got_w, exp_w); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_memory();
      test_input();
      test_output();
      test_overrun();
      test_status();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
